// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, waits for a stable lock, then releases sys_rst_n.
// Optional PLL_RETRY_LIMIT_EN: enter S_FAULT after MAX_RETRIES consecutive lock timeouts.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_lost_cnt,
  output logic [2:0] state
);
  localparam int unsigned CNT_W = 20;
  localparam int unsigned LLC_W = 8;

  typedef enum logic [2:0] {
    S_PLLRST    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  // Reject parameter values the counters cannot represent.
  if (RST_CYCLES < 2 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 2 || SYNC_STAGES < 2 ||
      RST_CYCLES > (2 ** CNT_W) || LOCK_TIMEOUT > (2 ** CNT_W) ||
      STABLE_CYCLES > (2 ** CNT_W) || MAX_RETRIES < 1 || MAX_RETRIES > 8) begin : g_param_check
    $error("pll_lock_sequencer: parameter out of range");
  end

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   timeout;
  logic [LLC_W-1:0]       llc_d;
  logic                   pll_rst_d, sys_rst_n_d, ready_d, fault_d;

`ifdef PLL_RETRY_LIMIT_EN
  localparam int unsigned RETRY_W = 3;
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  // pll_locked is asynchronous to refclk.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign state    = state_q;

  // Next state, counter and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    llc_d   = lock_lost_cnt;
    timeout = 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
    retry_d = retry_q;
`endif
    case (state_q)
      S_PLLRST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s)                                state_d = S_STABLE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))  timeout = 1'b1;
      end
      S_STABLE: begin
        if (!locked_s)                               state_d = S_WAIT_LOCK;
        else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
`ifdef PLL_RETRY_LIMIT_EN
        retry_d = '0;
`endif
        if (!locked_s) begin
          state_d = S_PLLRST;
          if (lock_lost_cnt != '1) llc_d = lock_lost_cnt + LLC_W'(1);
        end
      end
`ifdef PLL_RETRY_LIMIT_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_PLLRST;
    endcase

    if (timeout) begin
`ifdef PLL_RETRY_LIMIT_EN
      retry_d = retry_q + RETRY_W'(1);
      state_d = (retry_q == RETRY_W'(MAX_RETRIES - 1)) ? S_FAULT : S_PLLRST;
`else
      state_d = S_PLLRST;
`endif
    end

    // A soft request outranks lock loss and expiry but keeps the lock-loss count.
    if (soft_reset_req) begin
      state_d = S_PLLRST;
`ifdef PLL_RETRY_LIMIT_EN
      retry_d = '0;
`endif
    end

    if (soft_reset_req || (state_d != state_q)) cnt_d = '0;

    pll_rst_d   = (state_d == S_PLLRST) || (state_d == S_FAULT);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
`ifdef PLL_RETRY_LIMIT_EN
    fault_d     = (state_d == S_FAULT);
`else
    fault_d     = 1'b0;
`endif
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_PLLRST;
      cnt_q         <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst       <= pll_rst_d;
      sys_rst_n     <= sys_rst_n_d;
      ready         <= ready_d;
      fault         <= fault_d;
      lock_lost_cnt <= llc_d;
    end
  end

`ifdef PLL_RETRY_LIMIT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) retry_q <= '0;
    else        retry_q <= retry_d;
  end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues every expected output change with
// its refclk edge number; a monitor pops and compares each time the outputs change.
`timescale 1ns/100ps
module tb_pll_lock_sequencer;
  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 100;
  localparam int unsigned STABLE_CYCLES = 8;
  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned MAX_RETRIES   = 4;

  // Hand-computed edge offsets for the parameters above.
  localparam int unsigned T_WAIT   = 4;    // PLLRST entry -> WAIT_LOCK
  localparam int unsigned T_STABLE = 5;    // PLLRST entry -> STABLE (lock already synced)
  localparam int unsigned T_RUN    = 13;   // PLLRST entry -> RUN
  localparam int unsigned T_RETRY  = 104;  // PLLRST entry -> next PLLRST on timeout
  localparam int unsigned T_LOSS   = 3;    // pll_locked drop -> reaction edge

  localparam logic [2:0] S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4;

  logic       refclk = 1'b0;
  logic       rst_n, pll_locked, soft_reset_req;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state;

  pll_lock_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES(SYNC_STAGES), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
    .lock_lost_cnt(lock_lost_cnt), .state(state)
  );

  always #10 refclk = ~refclk;

  int unsigned cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  st;
    logic        prst, srn, rdy, flt;
    logic [7:0]  llc;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  llc_m;
  logic [14:0] obs, last;

  assign obs = {state, pll_rst, sys_rst_n, ready, fault, lock_lost_cnt};

  task automatic push(input string nm, input int unsigned c, input logic [2:0] st);
    exp_t e;
    e.cyc  = c;
    e.st   = st;
    e.prst = (st == S0) || (st == S4);
    e.srn  = (st == S3);
    e.rdy  = (st == S3);
    e.flt  = (st == S4);
    e.llc  = llc_m;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_front();
    exp_t  e;
    string nm;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_change: got cyc=%0d state=%0d pll_rst=%b sys_rst_n=%b ready=%b fault=%b llc=%0d, required no change",
               cyc, state, pll_rst, sys_rst_n, ready, fault, lock_lost_cnt);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (cyc != e.cyc || state !== e.st || pll_rst !== e.prst || sys_rst_n !== e.srn ||
          ready !== e.rdy || fault !== e.flt || lock_lost_cnt !== e.llc) begin
        errors++;
        $display("FAIL %s: got cyc=%0d state=%0d pll_rst=%b sys_rst_n=%b ready=%b fault=%b llc=%0d, required cyc=%0d state=%0d pll_rst=%b sys_rst_n=%b ready=%b fault=%b llc=%0d",
                 nm, cyc, state, pll_rst, sys_rst_n, ready, fault, lock_lost_cnt,
                 e.cyc, e.st, e.prst, e.srn, e.rdy, e.flt, e.llc);
      end
    end
  endtask

  // Monitor: compare whenever the observed outputs change.
  initial begin
    #2;
    check_front();
    last = obs;
    forever begin
      @(posedge refclk or negedge rst_n);
      #0.5;
      if (obs !== last) begin
        check_front();
        last = obs;
      end
    end
  end

  task automatic run_to(input int unsigned c);
    while (cyc < c) @(negedge refclk);
  endtask

  task automatic restart_to_run(input int unsigned p, input string nm, output int unsigned r);
    push({nm, "_wait"},   p + T_WAIT,   S1);
    push({nm, "_stable"}, p + T_STABLE, S2);
    push({nm, "_run"},    p + T_RUN,    S3);
    r = p + T_RUN;
  endtask

  task automatic lose_lock(input int unsigned r, input bit with_soft, input bit restore,
                           input string nm, output int unsigned p);
    p = r + T_LOSS;
    if (llc_m != 8'hFF) llc_m = llc_m + 8'd1;
    push(nm, p, S0);
    run_to(r);
    pll_locked = 1'b0;
    if (with_soft) begin
      run_to(p - 1);
      soft_reset_req = 1'b1;
    end
    run_to(p);
    soft_reset_req = 1'b0;
    if (restore) pll_locked = 1'b1;
  endtask

  task automatic soft_from_run(input int unsigned r, input string nm, output int unsigned p);
    p = r + 4;
    push(nm, p, S0);
    run_to(p - 1);
    soft_reset_req = 1'b1;
    run_to(p);
    soft_reset_req = 1'b0;
  endtask

  initial begin
    int unsigned base, r, p, s;
    rst_n = 1'b1; pll_locked = 1'b1; soft_reset_req = 1'b0; llc_m = 8'd0;
    #1 rst_n = 1'b0;
    push("reset_state", 0, S0);
    repeat (3) @(negedge refclk);
    rst_n = 1'b1;
    base  = cyc;

    // Locked throughout: 0 -> 1 at edge 4, 2 at edge 5, 3 at edge 13.
    restart_to_run(base, "bringup", r);

    // Lock loss in RUN, then soft request coinciding with lock loss.
    lose_lock(r, 1'b0, 1'b1, "lock_loss1", p);
    restart_to_run(p, "relock1", r);
    lose_lock(r, 1'b1, 1'b1, "loss_and_soft", p);
    restart_to_run(p, "relock2", r);

    // Soft restart from RUN, then a 3-cycle lock glitch in the 5th STABLE cycle.
    soft_from_run(r, "soft_in_run", p);
    s = p + T_STABLE;
    push("glitch_pre_wait",   p + T_WAIT, S1);
    push("glitch_pre_stable", s,          S2);
    push("glitch_wait",       s + 7,      S1);
    push("glitch_stable",     s + 10,     S2);
    push("glitch_run",        s + 18,     S3);
    run_to(s + 4); pll_locked = 1'b0;
    run_to(s + 7); pll_locked = 1'b1;
    r = s + 18;

    // 1 ns rst_n pulse mid-STABLE clears everything without a clock edge.
    soft_from_run(r, "soft_to_stable", p);
    s = p + T_STABLE;
    push("rst_pre_wait",   p + T_WAIT, S1);
    push("rst_pre_stable", s,          S2);
    run_to(s + 3);
    #2;
    llc_m = 8'd0;
    push("async_reset", cyc, S0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    base = cyc;
    restart_to_run(base, "post_rst", r);

    // Repeated lock loss saturates the counter at 255.
    for (int i = 0; i < 300; i++) begin
      lose_lock(r, 1'b0, 1'b1, "loss_loop", p);
      restart_to_run(p, "relock_loop", r);
    end

    // Lock held low: soft request in PLLRST restarts the pulse, then timeouts.
    lose_lock(r, 1'b0, 1'b0, "loss_hold_low", p);
    run_to(p + 1); soft_reset_req = 1'b1;
    run_to(p + 2); soft_reset_req = 1'b0;
    p = p + 2;
`ifdef PLL_RETRY_LIMIT_EN
    for (int k = 0; k < 4; k++) begin
      push("retry_wait", p + T_WAIT, S1);
      if (k < 3) push("retry_timeout", p + T_RETRY, S0);
      else       push("retry_fault",   p + T_RETRY, S4);
      p = p + T_RETRY;
    end
    run_to(p + 20);
    pll_locked = 1'b1;
    soft_reset_req = 1'b1;
    push("fault_exit", p + 21, S0);
    run_to(p + 21);
    soft_reset_req = 1'b0;
    restart_to_run(p + 21, "after_fault", r);
`else
    for (int k = 0; k < 20; k++) begin
      push("retry_wait",    p + T_WAIT,  S1);
      push("retry_timeout", p + T_RETRY, S0);
      p = p + T_RETRY;
    end
    run_to(p);
    pll_locked = 1'b1;
    restart_to_run(p, "after_retries", r);
`endif

    run_to(r + 5);
    begin
      int unsigned lim;
      lim = cyc + 50;
      while (exp_q.size() != 0 && cyc < lim) @(negedge refclk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected changes never observed, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
